// File: rtl/alu_result_collector.sv
// Collects ALU responses into a sequence-stamped show-ahead FIFO and hands them
// downstream; also accumulates sticky status flags across accepted responses.
module alu_result_collector #(
  parameter int DATA_W = 64,
  parameter int SEL_W  = 6,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_valid,
  output logic                     cap_ready,
  input  logic [SEL_W-1:0]         cap_sel,
  input  logic [DATA_W-1:0]        cap_result,
  input  logic [DATA_W-1:0]        cap_upper,
  input  logic [6:0]               cap_flags,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SEL_W-1:0]         rsp_sel,
  output logic [DATA_W-1:0]        rsp_result,
  output logic [DATA_W-1:0]        rsp_upper,
  output logic [6:0]               rsp_flags,
  output logic [SEQ_W-1:0]         rsp_seq,
  output logic [6:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid never depends on ready, and cap_ready is
  // derived from occupancy alone (a pop does not free a slot in the same cycle).
  logic [SEL_W-1:0]  mem_sel    [DEPTH];
  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [DATA_W-1:0] mem_upper  [DEPTH];
  logic [6:0]        mem_flags  [DEPTH];
  logic [SEQ_W-1:0]  mem_seq    [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [SEQ_W-1:0] seq_q;
  logic [6:0]       sticky_q;
  logic             accept;
  logic             pop;

  assign cap_ready    = (count_q < CW'(DEPTH));
  assign rsp_valid    = (count_q != '0);
  assign accept       = cap_valid & cap_ready;
  assign pop          = rsp_valid & rsp_ready;
  assign count        = count_q;
  assign sticky_flags = sticky_q;

  assign rsp_sel    = mem_sel[rd_ptr];
  assign rsp_result = mem_result[rd_ptr];
  assign rsp_upper  = mem_upper[rd_ptr];
  assign rsp_flags  = mem_flags[rd_ptr];
  assign rsp_seq    = mem_seq[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_sel[wr_ptr]    <= cap_sel;
      mem_result[wr_ptr] <= cap_result;
      mem_upper[wr_ptr]  <= cap_upper;
      mem_flags[wr_ptr]  <= cap_flags;
      mem_seq[wr_ptr]    <= seq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      seq_q   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq_q  <= seq_q + SEQ_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A clear coinciding with an accept restarts accumulation from that response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (sticky_clr) begin
      sticky_q <= accept ? cap_flags : 7'd0;
    end else if (accept) begin
      sticky_q <= sticky_q | cap_flags;
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector; a queue-based model
// predicts occupancy, handshakes, head entry and sticky flags every cycle.
module tb_alu_result_collector;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 6;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 8;
  localparam int EW     = SEL_W + 2 * DATA_W + 7 + SEQ_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cap_valid = 1'b0;
  logic                   cap_ready;
  logic [SEL_W-1:0]       cap_sel = '0;
  logic [DATA_W-1:0]      cap_result = '0;
  logic [DATA_W-1:0]      cap_upper = '0;
  logic [6:0]             cap_flags = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [SEL_W-1:0]       rsp_sel;
  logic [DATA_W-1:0]      rsp_result;
  logic [DATA_W-1:0]      rsp_upper;
  logic [6:0]             rsp_flags;
  logic [SEQ_W-1:0]       rsp_seq;
  logic [6:0]             sticky_flags;
  logic                   sticky_clr = 1'b0;
  logic [$clog2(DEPTH):0] count;

  alu_result_collector #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_sel(cap_sel),
    .cap_result(cap_result), .cap_upper(cap_upper), .cap_flags(cap_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel),
    .rsp_result(rsp_result), .rsp_upper(rsp_upper), .rsp_flags(rsp_flags),
    .rsp_seq(rsp_seq), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0]    exp_q[$];
  logic [SEQ_W-1:0] m_seq = '0;
  logic [6:0]       m_sticky = '0;

  always @(negedge clk) begin
    logic          m_ready;
    logic          m_acc;
    logic          m_pop;
    logic [EW-1:0] head;
    if (!rst_n) begin
      exp_q.delete();
      m_seq    = '0;
      m_sticky = '0;
      chk("reset_count", 160'(count), 160'(0));
      chk("reset_rsp_valid", 160'(rsp_valid), 160'(0));
      chk("reset_cap_ready", 160'(cap_ready), 160'(1));
      chk("reset_sticky", 160'(sticky_flags), 160'(0));
    end else begin
      m_ready = (exp_q.size() < DEPTH);
      m_acc   = cap_valid && m_ready;
      m_pop   = rsp_ready && (exp_q.size() != 0);
      chk("cap_ready", 160'(cap_ready), 160'(m_ready));
      chk("rsp_valid", 160'(rsp_valid), 160'(exp_q.size() != 0));
      chk("count", 160'(count), 160'(exp_q.size()));
      chk("sticky", 160'(sticky_flags), 160'(m_sticky));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("rsp_entry", 160'({rsp_sel, rsp_result, rsp_upper, rsp_flags, rsp_seq}), 160'(head));
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back({cap_sel, cap_result, cap_upper, cap_flags, m_seq});
        m_seq = m_seq + 1'b1;
      end
      if (sticky_clr) m_sticky = m_acc ? cap_flags : 7'd0;
      else if (m_acc) m_sticky = m_sticky | cap_flags;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    cap_sel    = SEL_W'($urandom_range(0, 63));
    cap_result = {$urandom, $urandom};
    cap_upper  = {$urandom, $urandom};
    cap_flags  = 7'($urandom_range(0, 127));
  endtask

  task automatic drain_to(input int target);
    int n;
    n = 0;
    cap_valid = 1'b0;
    rsp_ready = 1'b1;
    while (int'(count) != target && n < 40) begin
      step();
      n++;
    end
    rsp_ready = 1'b0;
    chk("drain_reached", 160'(count), 160'(target));
  endtask

  // Reset asserted between edges so the drop must be asynchronous.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    cap_valid  = 1'b0;
    rsp_ready  = 1'b0;
    sticky_clr = 1'b0;
    #1;
    chk("async_rsp_valid", 160'(rsp_valid), 160'(0));
    chk("async_count", 160'(count), 160'(0));
    chk("async_sticky", 160'(sticky_flags), 160'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  s;
    bit  acc;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // single capture
    cap_valid = 1'b1; cap_sel = 6'd3; cap_result = 64'h1234_ABCD_AA98_8765;
    cap_upper = '0; cap_flags = 7'b0010001;
    step();
    cap_valid = 1'b0;
    chk("single_seq", 160'(rsp_seq), 160'(0));
    chk("single_sel", 160'(rsp_sel), 160'(3));
    chk("single_sticky", 160'(sticky_flags), 160'(7'b0010001));
    step();
    drain_to(0);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;

    // fill until full, then pop while push is held off
    s = 0;
    cap_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cap_sel = SEL_W'(s);
      cap_result = {$urandom, $urandom}; cap_upper = {$urandom, $urandom};
      cap_flags = 7'($urandom_range(0, 127));
      acc = cap_ready;
      step();
      if (acc) s++;
    end
    chk("fill_accepts", 160'(s), 160'(8));
    chk("fill_count", 160'(count), 160'(8));
    chk("fill_ready", 160'(cap_ready), 160'(0));
    cap_sel = SEL_W'(s);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("full_pop_count", 160'(count), 160'(7));
    chk("full_pop_ready", 160'(cap_ready), 160'(1));
    step();
    cap_valid = 1'b0;
    chk("refill_count", 160'(count), 160'(8));

    // steady state at occupancy 3
    drain_to(3);
    cap_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      step();
    end
    chk("steady_count", 160'(count), 160'(3));
    drain_to(0);

    // 260-entry stream for sequence wrap
    mid_cycle_reset();
    cap_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 260; c++) begin
      rand_data();
      step();
    end
    cap_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("stream_empty", 160'(count), 160'(0));

    // sticky clear behaviour
    cap_valid = 1'b1; cap_flags = 7'b0000011; sticky_clr = 1'b1;
    step();
    chk("sticky_load", 160'(sticky_flags), 160'(7'b0000011));
    cap_flags = 7'b1000000;
    step();
    chk("sticky_clr_acc", 160'(sticky_flags), 160'(7'b1000000));
    cap_valid = 1'b0;
    step();
    sticky_clr = 1'b0;
    chk("sticky_clr_only", 160'(sticky_flags), 160'(0));
    drain_to(0);

    // fill to 5 then reset mid-cycle
    cap_valid = 1'b1; cap_flags = 7'b0101010;
    repeat (5) begin rand_data(); step(); end
    cap_valid = 1'b0;
    chk("pre_reset_count", 160'(count), 160'(5));
    mid_cycle_reset();
    cap_valid = 1'b1; rand_data();
    step();
    cap_valid = 1'b0;
    chk("post_reset_seq", 160'(rsp_seq), 160'(0));
    drain_to(0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      cap_valid  = 1'($urandom_range(0, 1));
      rsp_ready  = 1'($urandom_range(0, 1));
      sticky_clr = ($urandom_range(0, 15) == 0);
      rand_data();
      step();
    end
    sticky_clr = 1'b0;
    drain_to(0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
